// File: rtl/vga_pkg.sv
// Shared VGA constants and the overlay FSM encoding used across the pixel chain.
package vga_pkg;

   localparam int unsigned H_VISIBLE = 800;
   localparam int unsigned V_VISIBLE = 600;

   localparam logic [11:0] TRANSPARENT_RGB_DEF = 12'hF0F;

   typedef enum logic {
      WAIT_FRAME = 1'b0,
      ACTIVE     = 1'b1
   } rect_state_e;

endpackage

// File: rtl/vga_delay.sv
// N-stage shift register with synchronous active-low clear, used to align the timing bus.
module vga_delay #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] pipe_q [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH); i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= din;
         for (int i = 1; i < int'(DEPTH); i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/draw_image_rect.sv
// Overlays a RECT_WIDTH x RECT_HEIGHT ROM image on the VGA stream with colour-key
// transparency; position is latched once per frame at the vblank rising edge.
module draw_image_rect
   import vga_pkg::*;
#(
   parameter int unsigned RECT_WIDTH      = 64,
   parameter int unsigned RECT_HEIGHT     = 64,
   parameter logic [11:0] TRANSPARENT_RGB = TRANSPARENT_RGB_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] xpos,
   input  logic [11:0] ypos,
   input  logic [10:0] hcount_in,
   input  logic [10:0] vcount_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblnk_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   input  logic [11:0] rom_pixel,
   output logic [11:0] pixel_addr,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        hblnk_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out
);

   localparam int unsigned COL_W = $clog2(RECT_WIDTH);
   localparam int unsigned ROW_W = $clog2(RECT_HEIGHT);
   localparam logic [12:0] RW13  = 13'(RECT_WIDTH);
   localparam logic [12:0] RH13  = 13'(RECT_HEIGHT);
   localparam int unsigned BUS_W = 26;

   rect_state_e state_q, state_d;
   logic [11:0] xpos_s_q, ypos_s_q;
   logic        vblnk_prev_q;
   logic        vblnk_rise;
   logic        in_rect, in_rect_d1_q;
   logic [12:0] h13, v13, x13, y13, hoff, voff;
   logic [11:0] rgb_d1, rgb_mix;
   logic [BUS_W-1:0] bus_in, bus_out;

   assign vblnk_rise = vblnk_in & ~vblnk_prev_q;

   // Shadow position and vblank edge detector; reset beats a coincident edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         xpos_s_q     <= '0;
         ypos_s_q     <= '0;
         vblnk_prev_q <= 1'b0;
         state_q      <= WAIT_FRAME;
      end else begin
         vblnk_prev_q <= vblnk_in;
         state_q      <= state_d;
         if (vblnk_rise) begin
            xpos_s_q <= xpos;
            ypos_s_q <= ypos;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         WAIT_FRAME: if (vblnk_rise) state_d = ACTIVE;
         ACTIVE:     state_d = ACTIVE;
         default:    state_d = WAIT_FRAME;
      endcase
   end

   // 13-bit compare so xpos_s + width never wraps; off-screen parts are clipped by blanking.
   always_comb begin
      h13  = {2'b00, hcount_in};
      v13  = {2'b00, vcount_in};
      x13  = {1'b0, xpos_s_q};
      y13  = {1'b0, ypos_s_q};
      hoff = h13 - x13;
      voff = v13 - y13;
      in_rect = (h13 >= x13) && (h13 < x13 + RW13) &&
                (v13 >= y13) && (v13 < y13 + RH13) &&
                !hblnk_in && !vblnk_in;
   end

   assign pixel_addr = 12'({voff[ROW_W-1:0], hoff[COL_W-1:0]});

   assign bus_in = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};

   vga_delay #(
      .WIDTH (BUS_W),
      .DEPTH (2)
   ) u_timing_delay (
      .clk  (clk),
      .rst  (rst),
      .din  (bus_in),
      .dout (bus_out)
   );

   assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = bus_out;

   vga_delay #(
      .WIDTH (12),
      .DEPTH (1)
   ) u_rgb_delay (
      .clk  (clk),
      .rst  (rst),
      .din  (rgb_in),
      .dout (rgb_d1)
   );

   always_comb begin
      rgb_mix = rgb_d1;
      if (state_q == ACTIVE && in_rect_d1_q && rom_pixel != TRANSPARENT_RGB) begin
         rgb_mix = rom_pixel;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         in_rect_d1_q <= 1'b0;
         rgb_out      <= '0;
      end else begin
         in_rect_d1_q <= in_rect;
         rgb_out      <= rgb_mix;
      end
   end

endmodule

// File: tb/tb_draw_image_rect.sv
// Randomised scoreboard bench for draw_image_rect with a synchronous ROM model.
module tb_draw_image_rect;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] xpos, ypos;
   logic [10:0] hcount_in, vcount_in;
   logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
   logic [11:0] rgb_in, rom_pixel, pixel_addr;
   logic [10:0] hcount_out, vcount_out;
   logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
   logic [11:0] rgb_out;

   always #5 clk = ~clk;

   draw_image_rect dut (
      .clk        (clk),
      .rst        (rst),
      .xpos       (xpos),
      .ypos       (ypos),
      .hcount_in  (hcount_in),
      .vcount_in  (vcount_in),
      .hsync_in   (hsync_in),
      .vsync_in   (vsync_in),
      .hblnk_in   (hblnk_in),
      .vblnk_in   (vblnk_in),
      .rgb_in     (rgb_in),
      .rom_pixel  (rom_pixel),
      .pixel_addr (pixel_addr),
      .hcount_out (hcount_out),
      .vcount_out (vcount_out),
      .hsync_out  (hsync_out),
      .vsync_out  (vsync_out),
      .hblnk_out  (hblnk_out),
      .vblnk_out  (vblnk_out),
      .rgb_out    (rgb_out)
   );

   logic [11:0] rom_mem [4096];
   always_ff @(posedge clk) rom_pixel <= rom_mem[pixel_addr];

   typedef struct {
      bit          r;
      logic [10:0] h, v;
      logic        hs, vs, hb, vb;
      logic [11:0] rgb;
   } exp_t;

   exp_t exp_q[$];
   exp_t m_e, m_n;
   int   checks = 0;
   int   passes = 0;

   // Reference state: image origin for the current frame and whether any frame has started.
   int sx = 0, sy = 0;
   bit active = 0, prev_vb = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %h, required %h", name, act, req);
   endtask

   task automatic cyc(input int h, input int v, input bit r);
      exp_t e;
      bit   hb, vb, in_r;
      int   addr;
      logic [11:0] pix;
      @(posedge clk);
      #1;
      hb = (h >= 800);
      vb = (v >= 600);
      rst = r;
      hcount_in = h[10:0];
      vcount_in = v[10:0];
      hblnk_in = hb;
      vblnk_in = vb;
      hsync_in = 1'($urandom);
      vsync_in = 1'($urandom);
      rgb_in = 12'($urandom);
      in_r = (h >= sx) && (h < sx + 64) && (v >= sy) && (v < sy + 64) && !hb && !vb;
      addr = in_r ? (v - sy) * 64 + (h - sx) : 0;
      pix = rom_mem[addr];
      e.r = r;
      e.h = h[10:0];
      e.v = v[10:0];
      e.hs = hsync_in;
      e.vs = vsync_in;
      e.hb = hb;
      e.vb = vb;
      e.rgb = (active && in_r && pix != 12'hF0F) ? pix : rgb_in;
      exp_q.push_back(e);
      #1;
      if (in_r) check("pixel_addr", {20'd0, pixel_addr}, addr);
      if (!r) begin
         sx = 0; sy = 0; active = 0; prev_vb = 0;
      end else begin
         if (vb && !prev_vb) begin
            sx = int'(xpos); sy = int'(ypos); active = 1;
         end
         prev_vb = vb;
      end
   endtask

   task automatic vblank();
      for (int i = 0; i < 4; i++) cyc(i * 10, 600 + i, 1);
   endtask

   // Outputs carry the stimulus of two clocks earlier, or zero if reset hit during flight.
   always @(negedge clk) begin
      if (exp_q.size() >= 3) begin
         m_e = exp_q.pop_front();
         m_n = exp_q[0];
         if (!m_e.r || !m_n.r) begin
            m_e.h = '0; m_e.v = '0; m_e.hs = 0; m_e.vs = 0;
            m_e.hb = 0; m_e.vb = 0; m_e.rgb = '0;
         end
         check("timing_bus",
               {6'd0, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out},
               {6'd0, m_e.h, m_e.v, m_e.hs, m_e.vs, m_e.hb, m_e.vb});
         check("rgb_out", {20'd0, rgb_out}, {20'd0, m_e.rgb});
      end
   end

   initial begin
      logic [11:0] val;
      for (int a = 0; a < 4096; a++) begin
         val = 12'($urandom);
         if (a % 64 == 3) val = 12'hF0F;
         else if (val == 12'hF0F) val = 12'hABC;
         rom_mem[a] = val;
      end
      rom_mem[0] = 12'hABC;
      rom_mem[4095] = 12'hABC;
      xpos = 12'd100;
      ypos = 12'd50;

      // Reset, then a frame before any vblank: no overlay even inside the rect.
      for (int i = 0; i < 5; i++) cyc($urandom_range(799, 0), $urandom_range(599, 0), 0);
      check("reset_rgb_out", {20'd0, rgb_out}, 32'd0);
      check("reset_hcount_out", {21'd0, hcount_out}, 32'd0);
      for (int v = 48; v <= 60; v++)
         for (int h = 96; h <= 170; h++) cyc(h, v, 1);

      // First framed draw; xpos moves mid-frame and must not take effect yet.
      vblank();
      for (int v = 48; v <= 116; v++) begin
         if (v == 80) xpos = 12'd200;
         for (int h = 96; h <= 168; h++) begin
            cyc(h, v, 1);
            if (h == 100 && v == 50) check("addr_first", {20'd0, pixel_addr}, 32'h000);
            if (h == 163 && v == 113) check("addr_last", {20'd0, pixel_addr}, 32'hFFF);
         end
      end

      vblank();
      for (int v = 48; v <= 116; v++)
         for (int h = 190; h <= 270; h++) cyc(h, v, 1);

      // Clipping at the bottom-right corner, with row/column 0 probed for wrap.
      xpos = 12'd780;
      ypos = 12'd580;
      vblank();
      for (int v = 0; v < 600; v++) begin
         if (v > 2 && v < 576) continue;
         for (int h = 0; h <= 805; h++) begin
            if ((h > 3 && h < 60) || (h > 66 && h < 776)) continue;
            cyc(h, v, 1);
         end
      end

      // Reset in the middle of a rect line; overlay returns only after next vblank.
      xpos = 12'd300;
      ypos = 12'd100;
      vblank();
      for (int v = 100; v <= 103; v++)
         for (int h = 296; h <= 370; h++) cyc(h, v, !(v == 102 && (h == 320 || h == 321)));
      vblank();
      for (int v = 100; v <= 104; v++)
         for (int h = 296; h <= 370; h++) cyc(h, v, 1);

      // Random frames with random positions, mid-frame moves and rare resets.
      for (int f = 0; f < 6; f++) begin
         xpos = 12'($urandom_range(820, 0));
         ypos = 12'($urandom_range(620, 0));
         vblank();
         for (int i = 0; i < 400; i++) begin
            int h, v;
            h = int'(xpos) - 8 + int'($urandom_range(80, 0));
            v = int'(ypos) - 8 + int'($urandom_range(80, 0));
            if (h < 0) h = 0;
            if (v < 0) v = 0;
            if (v > 599) v = 599;
            if ($urandom_range(99, 0) == 0) xpos = 12'($urandom_range(820, 0));
            cyc(h, v, $urandom_range(299, 0) != 0);
         end
      end

      for (int i = 0; i < 4; i++) cyc(900, 10, 1);
      @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
